// File: rtl/image_pipe_fifo.sv
// image_pipe_fifo: elastic buffer that sits after the image pipe stage.
// Stores 32-bit pixel beats with end-of-frame markers and re-drives them
// through a registered output stage that honours downstream busy.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   is_data_in        slave pixel data
//   is_valid_in       slave beat valid (accepted regardless of is_busy_out)
//   is_end_in         slave last beat of frame
//   is_busy_out       almost-full indication, AFULL_SLACK entries of slack
//   im_data_out       master pixel data
//   im_valid_out      master beat valid
//   im_end_out        master last beat of frame
//   im_busy_in        downstream stall
//   level_out         storage occupancy (excludes the output register)
//   overflow_out      sticky: a beat was dropped because storage was full
//   frame_cnt_out     frames delivered; live only when IMAGE_PIPE_FIFO_STATS_EN
//                     is defined, otherwise tied to 0
module image_pipe_fifo #(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AW          = 4,
  parameter int unsigned AFULL_SLACK = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [31:0]   is_data_in,
  input  logic          is_valid_in,
  input  logic          is_end_in,
  output logic          is_busy_out,
  output logic [31:0]   im_data_out,
  output logic          im_valid_out,
  output logic          im_end_out,
  input  logic          im_busy_in,
  output logic [AW:0]   level_out,
  output logic          overflow_out,
  output logic [15:0]   frame_cnt_out
);

  localparam logic [AW:0] FullLevel  = (AW + 1)'(DEPTH);
  localparam logic [AW:0] AfullLevel = (AW + 1)'(DEPTH - AFULL_SLACK);

  logic [32:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic          busy_q;
  logic          overflow_q;
  logic [31:0]   out_data_q;
  logic          out_valid_q;
  logic          out_end_q;

  logic out_free;
  logic pop;
  logic push;
  logic drop;

  // The output register can take a new beat when it is empty or being consumed.
  assign out_free = !out_valid_q || !im_busy_in;
  assign pop      = out_free && (level_q != '0);
  // A pop in the same cycle frees the slot a full store needs for the new beat.
  assign push     = is_valid_in && ((level_q != FullLevel) || pop);
  assign drop     = is_valid_in && !push;

  always_comb begin
    level_d = level_q;
    unique case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  // Storage array carries no reset; pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {is_end_in, is_data_in};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      busy_q      <= 1'b0;
      overflow_q  <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_end_q   <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      level_q <= level_d;
      busy_q  <= (level_d >= AfullLevel);
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (out_free) begin
        if (pop) begin
          out_data_q  <= mem_q[rd_ptr_q][31:0];
          out_end_q   <= mem_q[rd_ptr_q][32];
          out_valid_q <= 1'b1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign is_busy_out  = busy_q;
  assign im_data_out  = out_data_q;
  assign im_valid_out = out_valid_q;
  assign im_end_out   = out_end_q;
  assign level_out    = level_q;
  assign overflow_out = overflow_q;

`ifdef IMAGE_PIPE_FIFO_STATS_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else if (out_valid_q && !im_busy_in && out_end_q) begin
      frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_out = frame_cnt_q;
`else
  assign frame_cnt_out = 16'd0;
`endif

endmodule

// File: tb/tb_image_pipe_fifo.sv
module tb_image_pipe_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] is_data_in;
  logic        is_valid_in;
  logic        is_end_in;
  logic        is_busy_out;
  logic [31:0] im_data_out;
  logic        im_valid_out;
  logic        im_end_out;
  logic        im_busy_in;
  logic [4:0]  level_out;
  logic        overflow_out;
  logic [15:0] frame_cnt_out;

  int tests = 0;
  int fails = 0;

  image_pipe_fifo #(
    .DEPTH       (16),
    .AW          (4),
    .AFULL_SLACK (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .is_data_in    (is_data_in),
    .is_valid_in   (is_valid_in),
    .is_end_in     (is_end_in),
    .is_busy_out   (is_busy_out),
    .im_data_out   (im_data_out),
    .im_valid_out  (im_valid_out),
    .im_end_out    (im_end_out),
    .im_busy_in    (im_busy_in),
    .level_out     (level_out),
    .overflow_out  (overflow_out),
    .frame_cnt_out (frame_cnt_out)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic e);
    is_valid_in = v;
    is_data_in  = d;
    is_end_in   = e;
  endtask

  initial begin
    logic [15:0] exp_fc;
    rst_n       = 1'b0;
    im_busy_in  = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    chk("rst_valid", 64'(im_valid_out), 64'd0);
    chk("rst_data", 64'(im_data_out), 64'd0);
    chk("rst_end", 64'(im_end_out), 64'd0);
    chk("rst_level", 64'(level_out), 64'd0);
    chk("rst_busy", 64'(is_busy_out), 64'd0);
    chk("rst_ovf", 64'(overflow_out), 64'd0);
    chk("rst_fcnt", 64'(frame_cnt_out), 64'd0);
    rst_n = 1'b1;

    // Streaming: 8 beats, 2-edge latency, level never above 1.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 32'h10 + 32'(i), i == 7);
      tick();
      chk("s_valid", 64'(im_valid_out), 64'(i >= 1));
      if (i >= 1) chk("s_data", 64'(im_data_out), 64'h10 + 64'(i - 1));
      chk("s_level", 64'(level_out), 64'd1);
      chk("s_busy", 64'(is_busy_out), 64'd0);
    end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("s_last_data", 64'(im_data_out), 64'h17);
    chk("s_last_end", 64'(im_end_out), 64'd1);
    tick();
    chk("s_idle_valid", 64'(im_valid_out), 64'd0);
    chk("s_idle_level", 64'(level_out), 64'd0);

    // Backpressure: 15 beats under busy, almost-full at level 14.
    im_busy_in = 1'b1;
    for (int i = 0; i < 15; i++) begin
      drive(1'b1, 32'h20 + 32'(i), 1'b0);
      tick();
      chk("bp_level", 64'(level_out), (i == 0) ? 64'd1 : 64'(i));
      chk("bp_busy", 64'(is_busy_out), 64'(((i == 0) ? 1 : i) >= 14));
      if (i >= 1) chk("bp_hold", 64'(im_data_out), 64'h20);
    end
    drive(1'b0, 32'h0, 1'b0);
    im_busy_in = 1'b0;
    for (int j = 1; j < 15; j++) begin
      tick();
      chk("bp_drain", 64'(im_data_out), 64'h20 + 64'(j));
      chk("bp_drain_v", 64'(im_valid_out), 64'd1);
      if (j == 1) chk("bp_busy_fall", 64'(is_busy_out), 64'd0);
    end
    tick();
    chk("bp_empty", 64'(im_valid_out), 64'd0);

    // Overflow: 18 beats under busy, the last one dropped.
    im_busy_in = 1'b1;
    for (int i = 0; i < 18; i++) begin
      drive(1'b1, 32'h40 + 32'(i), 1'b0);
      tick();
      if (i == 16) chk("ov_pre", 64'(overflow_out), 64'd0);
    end
    chk("ov_level", 64'(level_out), 64'd16);
    chk("ov_flag", 64'(overflow_out), 64'd1);
    drive(1'b0, 32'h0, 1'b0);
    im_busy_in = 1'b0;
    for (int j = 1; j < 17; j++) begin
      tick();
      chk("ov_drain", 64'(im_data_out), 64'h40 + 64'(j));
    end
    tick();
    chk("ov_17_only", 64'(im_valid_out), 64'd0);
    chk("ov_sticky", 64'(overflow_out), 64'd1);

    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("ov_cleared", 64'(overflow_out), 64'd0);

    // Full storage with concurrent push and pop across pointer wrap.
    im_busy_in = 1'b1;
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 32'h50 + 32'(i), 1'b0);
      tick();
    end
    chk("fp_full", 64'(level_out), 64'd16);
    im_busy_in = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive(1'b1, 32'h70 + 32'(k), 1'b0);
      tick();
      chk("fp_level", 64'(level_out), 64'd16);
      chk("fp_data", 64'(im_data_out), 64'h51 + 64'(k));
    end
    chk("fp_no_ovf", 64'(overflow_out), 64'd0);
    drive(1'b0, 32'h0, 1'b0);
    for (int m = 0; m < 16; m++) begin
      tick();
      chk("fp_drain", 64'(im_data_out), (m < 10) ? 64'h57 + 64'(m) : 64'h70 + 64'(m - 10));
    end
    tick();
    chk("fp_empty", 64'(im_valid_out), 64'd0);

    // Reset mid-frame with 5 beats stored.
    im_busy_in = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h90 + 32'(i), 1'b0);
      tick();
    end
    chk("mr_level5", 64'(level_out), 64'd5);
    drive(1'b0, 32'h0, 1'b0);
    im_busy_in = 1'b0;
    rst_n = 1'b0;
    tick();
    chk("mr_valid", 64'(im_valid_out), 64'd0);
    chk("mr_data", 64'(im_data_out), 64'd0);
    chk("mr_level", 64'(level_out), 64'd0);
    chk("mr_busy", 64'(is_busy_out), 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'hA0 + 32'(i), i == 2);
      tick();
      if (i >= 1) chk("mr_fresh", 64'(im_data_out), 64'hA0 + 64'(i - 1));
    end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    chk("mr_fresh_last", 64'({im_end_out, im_data_out}), 64'h1_0000_00A2);
    tick();
    chk("mr_fresh_idle", 64'(im_valid_out), 64'd0);

    // Frame counter: 3 frames of 4 beats.
`ifdef IMAGE_PIPE_FIFO_STATS_EN
    exp_fc = 16'd3;
`else
    exp_fc = 16'd0;
`endif
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 32'hC0 + 32'(i), (i % 4) == 3);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    tick();
    chk("fc_three", 64'(frame_cnt_out), 64'(exp_fc));
`ifdef IMAGE_PIPE_FIFO_STATS_EN
    for (int i = 0; i < 65536; i++) begin
      drive(1'b1, 32'(i), 1'b1);
      tick();
    end
    drive(1'b0, 32'h0, 1'b0);
    tick();
    tick();
    tick();
    chk("fc_wrap", 64'(frame_cnt_out), 64'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
